// File: rtl/regdump_pkg.sv
// rtl/regdump_pkg.sv - shared widths, FSM encoding and pointer wrap helper for the dump reader
package regdump_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Wraps at NUM_REGS rather than 2**ADDR_W so non-power-of-two files work.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(NUM_REGS - 1)) ? '0 : a + 1'b1;
    endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// rtl/regfile_dump_reader_if.sv - control, register file read port and output stream of the dump reader
interface regfile_dump_reader_if;
    import regdump_pkg::*;

    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    logic              wr_stall;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;

    modport master (
        input  start, abort, first_addr, last_addr, wr_stall, rd_data, out_ready,
        output rd_addr, out_valid, out_addr, out_data, busy, done
    );

    modport slave (
        output start, abort, first_addr, last_addr, wr_stall, rd_data, out_ready,
        input  rd_addr, out_valid, out_addr, out_data, busy, done
    );

endinterface

// File: rtl/regdump_addr_ptr.sv
// rtl/regdump_addr_ptr.sv - loadable wrap-around register pointer with end-of-range match
module regdump_addr_ptr
    import regdump_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_inc,
    input  logic [ADDR_W-1:0] i_first,
    input  logic [ADDR_W-1:0] i_last,
    output logic [ADDR_W-1:0] o_ptr,
    output logic              o_at_end
);

    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_end;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
            r_end <= '0;
        end else if (i_load) begin
            r_ptr <= i_first;
            r_end <= i_last;
        end else if (i_inc) begin
            r_ptr <= wrap_inc(r_ptr);
        end
    end

    assign o_ptr    = r_ptr;
    assign o_at_end = (r_ptr == r_end);

endmodule

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a register range through one read port and streams (addr, data) words
module regfile_dump_reader
    import regdump_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    regfile_dump_reader_if.master bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_out_addr;
    logic [DATA_W-1:0] r_out_data;
    logic              r_done;

    logic              w_load;
    logic              w_inc;
    logic              w_capture;
    logic              w_done_nxt;
    logic [ADDR_W-1:0] w_ptr;
    logic              w_at_end;

    regdump_addr_ptr u_ptr (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (w_load),
        .i_inc    (w_inc),
        .i_first  (bus.first_addr),
        .i_last   (bus.last_addr),
        .o_ptr    (w_ptr),
        .o_at_end (w_at_end)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_out_addr <= '0;
            r_out_data <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (w_capture) begin
                r_out_addr <= w_ptr;
                r_out_data <= bus.rd_data;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_inc       = 1'b0;
        w_capture   = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (!bus.wr_stall) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                // Abort wins over a concurrent handshake: the word is gone but no DONE.
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.out_ready) begin
                    if (w_at_end) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_inc       = 1'b1;
                        w_state_nxt = ST_READ;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.rd_addr   = w_ptr;
    assign bus.out_valid = (r_state == ST_OUT);
    assign bus.out_addr  = r_out_addr;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.done      = r_done;

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Reader-side companion to the 32x32 register file: walks a programmable register address range through one read port and streams each (address, data) pair out over a valid/ready handshake.
- Used for state dump and debug readout, and by the bench as the checker-side consumer of the register file's write traffic.
- Sits beside the register file.
  - Drives the read address (RSA-style port) and samples the combinational read data (RSR-style port).
  - Stalls while the register file is being written.

Parameters:
ADDR_W, 5, register address width
DATA_W, 32, register data width
NUM_REGS, 32, number of registers; address pointer wraps modulo NUM_REGS

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
START  input  1  one-cycle request to begin a dump; honoured only in IDLE
ABORT  input  1  synchronous cancel of a dump in progress
FIRST_ADDR  input  ADDR_W  first register of the range, sampled on accepted START
LAST_ADDR  input  ADDR_W  last register of the range, sampled on accepted START
WR_STALL  input  1  register file write enable (WR); reads are deferred while high
RD_ADDR  output  ADDR_W  register file read address
RD_DATA  input  DATA_W  combinational register file read data for RD_ADDR
OUT_VALID  output  1  output word valid
OUT_READY  input  1  downstream ready
OUT_ADDR  output  ADDR_W  address of the word on OUT_DATA
OUT_DATA  output  DATA_W  captured register value
BUSY  output  1  high from accepted START until return to IDLE
DONE  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (RST_N low, any time, including mid-dump):
  - State=IDLE; RD_ADDR=0; OUT_VALID=0; OUT_ADDR=0; OUT_DATA=0; BUSY=0; DONE=0.
  - Latched range cleared to 0.
  - No DONE after reset release.
- States: IDLE, READ, OUT.
- IDLE:
  - START=1 latches FIRST_ADDR into the pointer and LAST_ADDR into the end register; next state is READ; BUSY=1 from the next cycle.
  - START while BUSY is ignored.
- READ:
  - RD_ADDR = pointer, driven from a register.
  - WR_STALL=1: remain in READ; no capture.
  - WR_STALL=0: capture RD_DATA into OUT_DATA and pointer into OUT_ADDR; next state OUT; OUT_VALID=1 in the next cycle.
- OUT:
  - OUT_VALID=1. OUT_ADDR and OUT_DATA hold stable until OUT_READY=1 (AXI-style: VALID never drops without a handshake except on ABORT or reset).
  - Handshake with pointer==end: OUT_VALID=0, DONE=1 for exactly one cycle, BUSY=0, back to IDLE.
  - Handshake otherwise: pointer = (pointer+1) mod NUM_REGS; back to READ.
- Throughput and latency:
  - One word per 2 cycles with OUT_READY tied high and no stalls.
  - First OUT_VALID appears 2 cycles after START with no stall.
- Range rules:
  - FIRST_ADDR==LAST_ADDR: exactly one word.
  - FIRST_ADDR>LAST_ADDR: wrap-around, i.e. FIRST..NUM_REGS-1 then 0..LAST.
  - Full dump: FIRST=0, LAST=31 gives 32 words.
- ABORT (any non-IDLE state):
  - Next cycle: IDLE, OUT_VALID=0, BUSY=0, no DONE.
  - ABORT and START together in IDLE: START wins.
- Simultaneous events:
  - ABORT in OUT together with OUT_READY=1: the word counts as consumed, but no DONE is issued even if it was the last word.
  - WR_STALL only affects READ; it is ignored in OUT.
  - A register written between capture and handshake is not re-read (snapshot semantics per word).

Decomposition:
- Shared package regdump_pkg: ADDR_W/DATA_W/NUM_REGS defaults, state encoding constants (IDLE=2'd0, READ=2'd1, OUT=2'd2).
- One natural sub-module: regdump_addr_ptr (loadable wrap-around address counter with terminal-match flag ptr==end).
- FSM and output register stay in the top.

Test Plan:
- Regfile preloaded r0=56, r1=64, r19=213142345; START with FIRST=0, LAST=1, OUT_READY=1 -> (0,56), then (1,64); DONE pulses once; 4 output cycles total.
- FIRST=LAST=19 -> single word (19,213142345); OUT_VALID high 1 cycle; DONE on the following cycle.
- FIRST=30, LAST=1, regfile rN=N+100 -> addresses 30,31,0,1 with data 130,131,100,101; then DONE.
- OUT_READY low for 5 cycles while OUT_VALID=1 -> OUT_ADDR/OUT_DATA stable across all 5; pointer does not advance; WR_STALL high for 3 cycles in READ -> no capture until it falls.
- ABORT during the third word of 0..31 -> OUT_VALID=0 and BUSY=0 next cycle; no DONE. RST_N low mid-dump -> all outputs 0 immediately (asynchronous). START while BUSY -> ignored, range unchanged.
